pingpong_rd_checker: RTL

Downstream consumer of the ping-pong RAM controller's 16-bit read stream, clocked in the read domain. Tracks the byte sequence packed two per word and flags any gap or corruption. Reports lock status, per-frame completion, and saturating error and frame counters to the debug/LED logic. It is purely an observer: it never back-pressures the controller.

---
 rtl/pingpong_rd_checker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pingpong_rd_checker.sv
// Sequence checker for the ping-pong RAM read stream: lock tracking, frame and error counting.
// Optional first-mismatch capture is built when PPCHK_CAPTURE_EN is defined.
module pingpong_rd_checker #(
    parameter int SEQ_MAX    = 199,
    parameter int MISS_LIMIT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk_25m,
    input  logic             rst,
    input  logic             word_valid,
    input  logic [15:0]      word_in,
    input  logic             clr,
    output logic             locked,
    output logic             frame_done,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [15:0]      cap_word,
    output logic [7:0]       cap_exp,
    output logic             dbg_state
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]       LAST_LO  = 8'(SEQ_MAX - 1);
    localparam logic [7:0]       LAST_HI  = 8'(SEQ_MAX);
    localparam logic [3:0]       MISS_LIM = 4'(MISS_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       exp_q, exp_d;
    logic [3:0]       miss_q, miss_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             frame_done_q, err_pulse_q;

    logic [7:0] lo_byte, hi_byte, lo_even, adv_exp, resync_exp;
    logic       well_formed, frame_hit, mismatch;

    // word_valid is a pure qualifier: there is no ready, every valid word is consumed that cycle.
    assign lo_byte     = word_in[7:0];
    assign hi_byte     = word_in[15:8];
    assign well_formed = !lo_byte[0] && (lo_byte <= LAST_LO) && (hi_byte == lo_byte + 8'd1);
    assign adv_exp     = (lo_byte == LAST_LO) ? 8'd0 : lo_byte + 8'd2;
    assign lo_even     = {lo_byte[7:1], 1'b0};
    // After a mismatch, expect the word that would follow the received one.
    assign resync_exp  = (lo_even >= LAST_LO) ? 8'd0 : lo_even + 8'd2;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        miss_d    = miss_q;
        frame_hit = 1'b0;
        mismatch  = 1'b0;
        if (word_valid) begin
            if (state_q == SEARCH) begin
                if (well_formed) begin
                    state_d   = LOCKED;
                    exp_d     = adv_exp;
                    miss_d    = 4'd0;
                    frame_hit = (hi_byte == LAST_HI);
                end
            end else if (well_formed && (lo_byte == exp_q)) begin
                exp_d     = adv_exp;
                miss_d    = 4'd0;
                frame_hit = (hi_byte == LAST_HI);
            end else begin
                mismatch = 1'b1;
                exp_d    = resync_exp;
                if (miss_q + 4'd1 >= MISS_LIM) begin
                    state_d = SEARCH;
                    miss_d  = 4'd0;
                end else begin
                    miss_d = miss_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (clr) begin
            err_cnt_d   = '0;
            frame_cnt_d = '0;
        end else begin
            if (mismatch && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (frame_hit && (frame_cnt_q != CNT_MAX)) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state_q      <= SEARCH;
            exp_q        <= 8'd0;
            miss_q       <= 4'd0;
            err_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            miss_q       <= miss_d;
            err_cnt_q    <= err_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_hit;
            err_pulse_q  <= mismatch;
        end
    end

`ifdef PPCHK_CAPTURE_EN
    logic [15:0] cap_word_q, cap_word_d;
    logic [7:0]  cap_exp_q, cap_exp_d;
    logic        cap_vld_q, cap_vld_d;

    always_comb begin
        cap_word_d = cap_word_q;
        cap_exp_d  = cap_exp_q;
        cap_vld_d  = cap_vld_q;
        if (clr) begin
            cap_word_d = 16'd0;
            cap_exp_d  = 8'd0;
            cap_vld_d  = 1'b0;
        end else if (mismatch && !cap_vld_q) begin
            cap_word_d = word_in;
            cap_exp_d  = exp_q;
            cap_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            cap_word_q <= 16'd0;
            cap_exp_q  <= 8'd0;
            cap_vld_q  <= 1'b0;
        end else begin
            cap_word_q <= cap_word_d;
            cap_exp_q  <= cap_exp_d;
            cap_vld_q  <= cap_vld_d;
        end
    end

    assign cap_word = cap_word_q;
    assign cap_exp  = cap_exp_q;
`else
    assign cap_word = 16'd0;
    assign cap_exp  = 8'd0;
`endif

    assign locked     = (state_q == LOCKED);
    assign dbg_state  = state_q;
    assign frame_done = frame_done_q;
    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
